// File: rtl/video_tint_pkg.sv
// Shared types for the monochrome-to-RGB tint stage: gain codes, palette
// entries, the default palette and the width-generic sample expander.
package video_tint_pkg;

  localparam int MAXW     = 32;
  localparam int PAL_SIZE = 8;

  typedef enum logic [1:0] {
    GAIN_OFF      = 2'b00,
    GAIN_HALF     = 2'b01,
    GAIN_FULL     = 2'b10,
    GAIN_FULL_ALT = 2'b11
  } gain_t;

  typedef struct packed {
    gain_t r;
    gain_t g;
    gain_t b;
  } pal_entry_t;

  localparam pal_entry_t DEFAULT_PAL [PAL_SIZE] = '{
    '{GAIN_FULL, GAIN_FULL, GAIN_FULL},
    '{GAIN_FULL, GAIN_OFF,  GAIN_OFF },
    '{GAIN_OFF,  GAIN_FULL, GAIN_OFF },
    '{GAIN_OFF,  GAIN_OFF,  GAIN_FULL},
    '{GAIN_FULL, GAIN_HALF, GAIN_OFF },
    '{GAIN_OFF,  GAIN_FULL, GAIN_FULL},
    '{GAIN_FULL, GAIN_OFF,  GAIN_FULL},
    '{GAIN_HALF, GAIN_HALF, GAIN_HALF}
  };

  // Output bit (ow-1-i) takes input bit (dw-1-(i mod dw)): MSB-first
  // replication when widening, plain top-bit truncation when narrowing.
  function automatic logic [MAXW-1:0] expand_sample(input logic [MAXW-1:0] v,
                                                    input int dw, input int ow);
    logic [MAXW-1:0] o;
    logic [4:0]      oi;
    logic [4:0]      di;
    o = '0;
    for (int i = 0; i < MAXW; i++) begin
      if (i < ow) begin
        oi    = 5'(ow - 1 - i);
        di    = 5'(dw - 1 - (i % dw));
        o[oi] = v[di];
      end
    end
    return o;
  endfunction

  function automatic pal_entry_t pal_lookup(input int idx);
    if (idx >= 0 && idx < PAL_SIZE) return DEFAULT_PAL[3'(idx)];
    return DEFAULT_PAL[0];
  endfunction

endpackage

// File: rtl/video_tint_sync_edge.sv
// Rising-edge detector for a sync line, qualified by the pixel enable.
// The first ce_pix sample after reset only primes the history.
module video_tint_sync_edge
  import video_tint_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic ce_pix,
  input  logic sig,
  output logic rise
);

  logic prev;
  logic armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev  <= 1'b0;
      armed <= 1'b0;
    end else if (ce_pix) begin
      prev  <= sig;
      armed <= 1'b1;
    end
  end

  assign rise = ce_pix & armed & sig & ~prev;

endmodule

// File: rtl/video_tint_out.sv
// Monochrome-to-RGB output stage: palette tint, frame-aligned mode latch,
// line counter and two-stage pipeline. Define VIDEO_TINT_SCANLINE_EN for odd-line dimming.
module video_tint_out
  import video_tint_pkg::*;
#(
  parameter int DW     = 8,
  parameter int OW     = 8,
  parameter int NMODES = 8,
  parameter int MW     = 3,
  parameter int LW     = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce_pix,
  input  logic [DW-1:0] video_in,
  input  logic          hblank_in,
  input  logic          vblank_in,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic [MW-1:0] mode_req,
  input  logic          scan_en,
  output logic [OW-1:0] r_out,
  output logic [OW-1:0] g_out,
  output logic [OW-1:0] b_out,
  output logic          hs_out,
  output logic          vs_out,
  output logic          de_out,
  output logic [MW-1:0] mode_active,
  output logic [LW-1:0] line_cnt
);

  localparam logic [LW-1:0] LINE_MAX = '1;

  logic          vs_rise;
  logic          hs_rise;
  logic [MW-1:0] mode_nxt;
  logic [LW-1:0] line_nxt;

  logic [OW-1:0] pix_p0;
  pal_entry_t    pal_p0;
  logic          vld_p0;
  logic          hs_p0;
  logic          vs_p0;
  logic          dim_p0;

  function automatic logic [MW-1:0] clamp_mode(input logic [MW-1:0] m);
    if ({1'b0, m} >= (MW+1)'(NMODES)) return '0;
    return m;
  endfunction

  function automatic logic [OW-1:0] apply_gain(input gain_t g, input logic [OW-1:0] v,
                                               input logic dim);
    logic [OW-1:0] t;
    case (g)
      GAIN_OFF:  t = '0;
      GAIN_HALF: t = v >> 1;
      default:   t = v;
    endcase
    return dim ? (t >> 1) : t;
  endfunction

  video_tint_sync_edge u_vs_edge (
    .clk    (clk),
    .reset  (reset),
    .ce_pix (ce_pix),
    .sig    (vsync_in),
    .rise   (vs_rise)
  );

  video_tint_sync_edge u_hs_edge (
    .clk    (clk),
    .reset  (reset),
    .ce_pix (ce_pix),
    .sig    (hsync_in),
    .rise   (hs_rise)
  );

  // Next-state values also feed stage 1, so an edge-cycle pixel already sees them.
  always_comb begin
    mode_nxt = mode_active;
    line_nxt = line_cnt;
    if (vs_rise) begin
      mode_nxt = clamp_mode(mode_req);
      line_nxt = '0;
    end else if (hs_rise && line_cnt != LINE_MAX) begin
      line_nxt = line_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_active <= '0;
      line_cnt    <= '0;
    end else if (ce_pix) begin
      mode_active <= mode_nxt;
      line_cnt    <= line_nxt;
    end
  end

  // Stage 1: width expansion, palette fetch, timing capture
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_p0 <= '0;
      pal_p0 <= DEFAULT_PAL[0];
      vld_p0 <= 1'b0;
      hs_p0  <= 1'b0;
      vs_p0  <= 1'b0;
    end else if (ce_pix) begin
      pix_p0 <= OW'(expand_sample(MAXW'(video_in), DW, OW));
      pal_p0 <= pal_lookup(int'(mode_nxt));
      vld_p0 <= ~(hblank_in | vblank_in);
      hs_p0  <= hsync_in;
      vs_p0  <= vsync_in;
    end
  end

`ifdef VIDEO_TINT_SCANLINE_EN
  always_ff @(posedge clk) begin
    if (reset)       dim_p0 <= 1'b0;
    else if (ce_pix) dim_p0 <= scan_en & line_nxt[0];
  end
`else
  logic unused_scan_en;
  assign unused_scan_en = scan_en;
  assign dim_p0         = 1'b0;
`endif

  // Stage 2: gain, optional dimming, blanking
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out  <= '0;
      g_out  <= '0;
      b_out  <= '0;
      hs_out <= 1'b0;
      vs_out <= 1'b0;
      de_out <= 1'b0;
    end else if (ce_pix) begin
      r_out  <= vld_p0 ? apply_gain(pal_p0.r, pix_p0, dim_p0) : '0;
      g_out  <= vld_p0 ? apply_gain(pal_p0.g, pix_p0, dim_p0) : '0;
      b_out  <= vld_p0 ? apply_gain(pal_p0.b, pix_p0, dim_p0) : '0;
      hs_out <= hs_p0;
      vs_out <= vs_p0;
      de_out <= vld_p0;
    end
  end

endmodule
